// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined RISC-V core.
// It holds the PC and drives a req/ready instruction-memory port, then writes
// the IF/ID pipeline register while honouring hazard-unit stalls and flushes.
// A redirect (PCSrcE) makes any in-flight fetch stale, so that response is dropped.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add the MisalignD output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        PCSrcE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCplus4D,
  output logic        ValidD
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        MisalignD
`endif
);

  // addi x0,x0,0 -- the canonical bubble instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] addr_q, addr_d;   // doubles as the stale-address register in DISCARD
  logic        req_q, req_d;
  logic [31:0] hold_q, hold_d;   // parked response while a stall is active
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4d_q, pcp4d_d;
  logic        valid_q, valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
`endif

  logic [31:0] pcplus4;
  logic        id_write;         // load a real instruction into IF/ID
  logic        id_bubble;        // load a bubble into IF/ID
  logic [31:0] id_instr;

  // PC+4 wraps modulo 2^32 by plain 32-bit addition
  assign pcplus4 = pcf_q + 32'd4;

  // Next-state logic: FSM transitions, PC update, memory port and IF/ID contents
  always_comb begin
    state_d   = state_q;
    pcf_d     = pcf_q;
    hold_d    = hold_q;
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcp4d_d   = pcp4d_q;
    valid_d   = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    id_write  = 1'b0;
    id_bubble = 1'b0;
    id_instr  = imem_rdata;

    case (state_q)
      S_FETCH: begin
        if (PCSrcE) begin
          // Redirect wins over stalls; the current fetch is stale either way
          pcf_d     = pc_next;
          id_bubble = !StallD;
          if (!imem_ready) begin
            state_d = S_DISCARD;
          end
        end else if (imem_ready) begin
          if (StallF || StallD) begin
            hold_d    = imem_rdata;
            state_d   = S_HOLD;
            id_bubble = !StallD;
          end else begin
            id_write = 1'b1;
            id_instr = imem_rdata;
            pcf_d    = pc_next;
          end
        end else begin
          id_bubble = !StallD;
        end
      end

      S_HOLD: begin
        if (PCSrcE) begin
          pcf_d     = pc_next;
          state_d   = S_FETCH;
          id_bubble = !StallD;
        end else if (!StallF && !StallD) begin
          // PCF did not move while holding, so it still names the parked instruction
          id_write = 1'b1;
          id_instr = hold_q;
          pcf_d    = pc_next;
          state_d  = S_FETCH;
        end else begin
          id_bubble = !StallD;
        end
      end

      S_DISCARD: begin
        if (PCSrcE) begin
          pcf_d = pc_next;
        end
        if (imem_ready) begin
          state_d = S_FETCH;
        end
        id_bubble = !StallD;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Flush overrides both stall and any pending write
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = 1'b0;
`endif
    end else if (id_write) begin
      instr_d = id_instr;
      pcd_d   = pcf_q;
      pcp4d_d = pcplus4;
      valid_d = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = |pcf_q[1:0];
`endif
    end else if (id_bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    // Registered memory port: in DISCARD the old address is simply kept
    req_d  = (state_d != S_HOLD);
    addr_d = (state_d == S_FETCH) ? pcf_d : addr_q;
  end

  // State and pipeline registers; reset abandons any outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pcf_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b1;
      hold_q  <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      pcp4d_q <= 32'd4;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4d_q <= pcp4d_d;
      valid_q <= valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign PCF       = pcf_q;
  assign PCplus4F  = pcplus4;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCplus4D  = pcp4d_q;
  assign ValidD    = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign MisalignD = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an IF/ID scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        PCSrcE, StallF, StallD, FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, PCplus4F, InstrD, PCD, PCplus4D;
  logic        ValidD;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        MisalignD;
`endif

  logic [31:0] target;
  logic        force_en;
  logic [31:0] force_data;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } id_t;

  id_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata = force_en ? force_data : instr_of(imem_addr);
  assign pc_next    = PCSrcE ? target : PCplus4F;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_next    (pc_next),
    .PCSrcE     (PCSrcE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .PCplus4F   (PCplus4F),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCplus4D   (PCplus4D),
    .ValidD     (ValidD)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .MisalignD  (MisalignD)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_id(input logic [31:0] instr, input logic [31:0] pc);
    id_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    sb.push_back(e);
  endtask

  task automatic expect_id(input string tag);
    id_t e;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check32({tag, "_instr"}, InstrD, e.instr);
      check32({tag, "_pcd"}, PCD, e.pc);
      check32({tag, "_pc4d"}, PCplus4D, e.pc4);
      check1({tag, "_valid"}, ValidD, 1'b1);
    end
  endtask

  // One zero-wait fetch of address a that lands in IF/ID
  task automatic fetch_cycle(input string tag, input logic [31:0] a);
    check32({tag, "_addr"}, imem_addr, a);
    check1({tag, "_req"}, imem_req, 1'b1);
    push_id(instr_of(a), a);
    tick();
    expect_id(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; PCSrcE = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    imem_ready = 1'b1; target = 32'd0; force_en = 1'b0; force_data = 32'd0;

    // Reset values
    tick();
    check32("rst_pcf", PCF, RPC);
    check1("rst_req", imem_req, 1'b1);
    check32("rst_addr", imem_addr, RPC);
    check32("rst_instr", InstrD, NOP);
    check1("rst_valid", ValidD, 1'b0);
    check32("rst_pcd", PCD, 32'd0);
    check32("rst_pc4d", PCplus4D, 32'd4);
    check32("rst_pc4f", PCplus4F, RPC + 32'd4);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait streaming
    fetch_cycle("f100", 32'h100);
    fetch_cycle("f104", 32'h104);

    // Redirect while the fetch of 0x108 completes
    check32("redir_addr108", imem_addr, 32'h108);
    PCSrcE = 1'b1; target = 32'h200;
    tick();
    PCSrcE = 1'b0;
    check32("redir_pcf", PCF, 32'h200);
    check32("redir_addr", imem_addr, 32'h200);
    check1("redir_valid", ValidD, 1'b0);
    check32("redir_instr", InstrD, NOP);
    check32("redir_pcd_held", PCD, 32'h104);
    fetch_cycle("f200", 32'h200);
    PCSrcE = 1'b1; target = 32'h10C;
    tick();
    PCSrcE = 1'b0;
    check32("redir2_addr", imem_addr, 32'h10C);

    // Wait states with a redirect in the middle: stale response is dropped
    imem_ready = 1'b0;
    tick();
    check32("ws1_pcf", PCF, 32'h10C);
    check1("ws1_valid", ValidD, 1'b0);
    PCSrcE = 1'b1; target = 32'h300;
    tick();
    PCSrcE = 1'b0;
    check32("ws2_pcf", PCF, 32'h300);
    check32("ws2_addr", imem_addr, 32'h10C);
    check1("ws2_req", imem_req, 1'b1);
    check1("ws2_valid", ValidD, 1'b0);
    tick();
    check32("ws3_addr", imem_addr, 32'h10C);
    check1("ws3_valid", ValidD, 1'b0);
    imem_ready = 1'b1;
    tick();
    check32("ws4_addr", imem_addr, 32'h300);
    check1("ws4_valid", ValidD, 1'b0);
    check32("ws4_instr", InstrD, NOP);
    fetch_cycle("f300", 32'h300);

    // Response parked in HOLD across a two-cycle StallD
    check32("hold_addr", imem_addr, 32'h304);
    force_en = 1'b1; force_data = 32'hDEAD_BEEF; StallD = 1'b1;
    tick();
    force_en = 1'b0;
    check1("hold1_req", imem_req, 1'b0);
    check32("hold1_pcf", PCF, 32'h304);
    check32("hold1_instr", InstrD, instr_of(32'h300));
    check1("hold1_valid", ValidD, 1'b1);
    tick();
    check1("hold2_req", imem_req, 1'b0);
    StallD = 1'b0;
    push_id(32'hDEAD_BEEF, 32'h304);
    tick();
    expect_id("hold_rel");
    check32("hold_rel_pcf", PCF, 32'h308);
    check1("hold_rel_req", imem_req, 1'b1);
    check32("hold_rel_addr", imem_addr, 32'h308);

    // Flush together with StallD
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    FlushD = 1'b0; StallD = 1'b0;
    check32("flush_instr", InstrD, NOP);
    check1("flush_valid", ValidD, 1'b0);
    check32("flush_pcd", PCD, 32'h304);
    push_id(instr_of(32'h308), 32'h308);
    tick();
    expect_id("flush_rel");
    check32("flush_rel_addr", imem_addr, 32'h30C);

    // PC wrap at the top of the address space
    PCSrcE = 1'b1; target = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    check32("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check32("wrap_pc4f", PCplus4F, 32'd0);
    check1("wrap_valid", ValidD, 1'b0);
    fetch_cycle("ffffc", 32'hFFFF_FFFC);
    check32("wrap_pcf0", PCF, 32'd0);
    fetch_cycle("f000", 32'h0);

    // Wait state: IF/ID held under StallD, bubble once it drops
    imem_ready = 1'b0; StallD = 1'b1;
    tick();
    check32("wsd_instr", InstrD, instr_of(32'h0));
    check1("wsd_valid", ValidD, 1'b1);
    check32("wsd_pcf", PCF, 32'h4);
    StallD = 1'b0;
    tick();
    check1("wsb_valid", ValidD, 1'b0);
    check32("wsb_instr", InstrD, NOP);
    check32("wsb_pcd", PCD, 32'h0);
    check32("wsb_addr", imem_addr, 32'h4);

    // Reset during an outstanding fetch: no discard afterwards
    rst = 1'b1;
    #1;
    check32("rst2_pcf", PCF, RPC);
    check32("rst2_addr", imem_addr, RPC);
    check1("rst2_req", imem_req, 1'b1);
    check1("rst2_valid", ValidD, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;
    fetch_cycle("f100b", 32'h100);

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core. Holds the PC register, consumes the selected next-PC (`PCplus4F` or `JumpTargetE`, chosen by `PCSrcE`), and drives a req/ready instruction-memory port. Writes the IF/ID pipeline register, honouring hazard-unit stalls and flushes. Drops in-flight fetches made stale by a taken branch or jump.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_next` in 32: next-PC from the PC select mux.
- `PCSrcE` in 1: redirect; `pc_next` is then the EX-stage jump/branch target.
- `StallF` in 1: hold PCF.
- `StallD` in 1: hold IF/ID.
- `FlushD` in 1: clear IF/ID to a bubble.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` in 1: response valid this cycle (`imem_rdata` valid).
- `imem_rdata` in 32: fetched instruction.
- `PCF` out 32: current fetch PC.
- `PCplus4F` out 32: `PCF`+4, combinational, fed back to the PC select mux.
- `InstrD`, `PCD`, `PCplus4D` out 32 each: IF/ID register contents.
- `ValidD` out 1: IF/ID holds a real instruction.

## Operation
- FSM states: FETCH (`imem_req`=1, `imem_addr`=`PCF`), HOLD (`imem_req`=0, response parked in a 32-bit hold buffer), DISCARD (`imem_req`=1, `imem_addr`=stale address register, response dropped).
- FETCH, `PCSrcE`=1:
  - `PCF`<=`pc_next`.
  - If `imem_ready`=1, drop the response and stay in FETCH.
  - Otherwise latch the stale address and go to DISCARD.
- FETCH, `imem_ready`=1, no redirect:
  - If `StallF` or `StallD`: capture `imem_rdata` into the hold buffer and go to HOLD.
  - Otherwise write IF/ID with {`imem_rdata`, `PCF`, `PCF`+4, valid=1} and set `PCF`<=`pc_next`.
- FETCH, `imem_ready`=0, no redirect: `PCF` holds. If `StallD`=0, write a bubble to IF/ID.
- HOLD:
  - `PCSrcE`=1: drop the buffer, `PCF`<=`pc_next`, go to FETCH.
  - Else if `StallF`=0 and `StallD`=0: IF/ID<=buffer, `PCF`<=`pc_next`, go to FETCH.
  - Else stay in HOLD.
- DISCARD:
  - `PCSrcE`=1: `PCF`<=`pc_next`.
  - `imem_ready`=1: go to FETCH.
  - IF/ID receives bubbles unless `StallD`=1.
- Redirect priority: `PCSrcE` beats `StallF`.
- Flush priority: `FlushD` beats `StallD` and any IF/ID write.
- Bubble definition: `InstrD`=32'h0000_0013 (addi x0,x0,0), `ValidD`=0; `PCD` and `PCplus4D` hold their values.
- Arithmetic: `PCF`+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - `PCF`=`RESET_PC`, state=FETCH.
  - `imem_req`=1, `imem_addr`=`RESET_PC`.
  - `InstrD`=32'h13, `ValidD`=0, `PCD`=0, `PCplus4D`=4.
- Reset mid-fetch abandons the outstanding request with no discard.
- Zero-wait memory: one instruction per cycle; address issued in cycle n appears on `InstrD` in cycle n+1.
- Redirect in cycle n:
  - `PCF` = target in n+1.
  - Target is requested in n+1 if the old fetch completed in n; otherwise in the cycle after the stale response returns.
- HOLD release: the buffered instruction reaches IF/ID one cycle after stalls drop; the next request issues that same cycle.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: adds output `MisalignD` (1 bit). On every non-bubble IF/ID write it is set to (`PCF[1:0]`!=0); reset value 0; cleared with `FlushD`. A misaligned `PCF` is still fetched.
- Undefined: no `MisalignD` port and no check logic.

## Test plan
- Reset with `RESET_PC`=32'h100 and zero-wait memory -> `imem_addr` sequence 0x100, 0x104, 0x108; `InstrD` follows one cycle later; `ValidD`=1 from cycle 2.
- `PCSrcE`=1 with `pc_next`=0x200 while fetch of 0x108 is ready -> 0x108 never reaches IF/ID; next `imem_addr`=0x200.
- `imem_ready` held low 3 cycles at 0x10C, `PCSrcE` pulse to 0x300 in cycle 1 -> `imem_addr` stays 0x10C until ready; that response is dropped; then 0x300 is requested; `ValidD`=0 throughout.
- Response 0xDEADBEEF arrives with `StallD`=1 for 2 cycles -> HOLD, `imem_req`=0; `InstrD`=0xDEADBEEF one cycle after `StallD` drops; `PCF` advances by 4.
- `FlushD`=1 and `StallD`=1 together -> `InstrD`=0x13, `ValidD`=0 next cycle.
- `PCF`=0xFFFF_FFFC, no redirect -> `PCplus4F`=0; next fetch address 0x0.
